// File: rtl/mres_disp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : mres_disp
// Brief  : Captures an 8-bit result, converts it to BCD by shift-add-3 and
//          scans hundreds/tens/units onto a 4-digit common-anode display.
// Rev    : 1.0
// ============================================================================
module mres_disp #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter logic        LZB      = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] disp_high,
  input  logic [3:0] disp_low,
  input  logic       disp_load,
  output logic       disp_busy,
  output logic [3:0] disp_an,
  output logic [6:0] disp_seg
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic [3:0]  r_hun;
  logic [3:0]  r_ten;
  logic [3:0]  r_uni;
  logic [15:0] r_div;
  logic [1:0]  r_idx;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;

  logic [11:0] w_adj;
  logic [19:0] w_shift;
  logic        w_tick;
  logic [1:0]  w_idx_nx;
  logic        w_hun_blank;
  logic        w_ten_blank;
  logic [3:0]  w_an_nx;
  logic [6:0]  w_seg_nx;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct every nibble, then shift {bcd,bin} left.
  assign w_adj   = {add3(r_bcd[11:8]), add3(r_bcd[7:4]), add3(r_bcd[3:0])};
  assign w_shift = {w_adj, r_bin} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_bin   <= 8'd0;
      r_bcd   <= 12'd0;
      r_cnt   <= 3'd0;
      r_hun   <= 4'd0;
      r_ten   <= 4'd0;
      r_uni   <= 4'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (disp_load) begin
            r_bin   <= {disp_high, disp_low};
            r_bcd   <= 12'd0;
            r_cnt   <= 3'd0;
            r_state <= S_CONV;
            r_busy  <= 1'b1;
          end
        end
        S_CONV: begin
          r_bcd <= w_shift[19:8];
          r_bin <= w_shift[7:0];
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_hun   <= w_shift[19:16];
            r_ten   <= w_shift[15:12];
            r_uni   <= w_shift[11:8];
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_tick      = (r_div == SCAN_DIV - 16'd1);
  assign w_idx_nx    = r_idx + 2'd1;
  assign w_hun_blank = LZB && (r_hun == 4'd0);
  assign w_ten_blank = LZB && (r_hun == 4'd0) && (r_ten == 4'd0);

  always_comb begin
    w_an_nx  = 4'b1111;
    w_seg_nx = 7'b1111111;
    case (w_idx_nx)
      2'd0: begin
        w_an_nx  = 4'b1110;
        w_seg_nx = seg7(r_uni);
      end
      2'd1: begin
        w_an_nx  = 4'b1101;
        w_seg_nx = w_ten_blank ? 7'b1111111 : seg7(r_ten);
      end
      2'd2: begin
        w_an_nx  = 4'b1011;
        w_seg_nx = w_hun_blank ? 7'b1111111 : seg7(r_hun);
      end
      default: begin
        w_an_nx  = 4'b0111;
        w_seg_nx = 7'b1111111;
      end
    endcase
  end

  // Outputs are registered for the slot being entered, so they move only on ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= 16'd0;
      r_idx <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
    end else if (w_tick) begin
      r_div <= 16'd0;
      r_idx <= w_idx_nx;
      r_an  <= w_an_nx;
      r_seg <= w_seg_nx;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

  assign disp_busy = r_busy;
  assign disp_an   = r_an;
  assign disp_seg  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_mres_disp.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_mres_disp
// Brief  : Self-checking bench for mres_disp (LZB=1 and LZB=0 instances).
// Rev    : 1.0
// ============================================================================
module tb_mres_disp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] dh  = 4'd0;
  logic [3:0] dl  = 4'd0;
  logic       load = 1'b0;
  logic       busy1, busy0;
  logic [3:0] an1, an0;
  logic [6:0] seg1, seg0;

  int n_chk = 0;
  int n_err = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic [3:0] an_seq [4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] cap1 [4];
  logic [6:0] cap0 [4];

  typedef struct {
    logic [7:0] val;
    logic [6:0] e0;
    logic [6:0] e1;
    logic [6:0] e2;
  } vec_t;
  vec_t vt [6];

  mres_disp #(.SCAN_DIV(16'd4), .LZB(1'b1)) u_dut_lzb (
    .clk(clk), .rst(rst), .disp_high(dh), .disp_low(dl), .disp_load(load),
    .disp_busy(busy1), .disp_an(an1), .disp_seg(seg1));

  mres_disp #(.SCAN_DIV(16'd4), .LZB(1'b0)) u_dut_nolzb (
    .clk(clk), .rst(rst), .disp_high(dh), .disp_low(dl), .disp_load(load),
    .disp_busy(busy0), .disp_an(an0), .disp_seg(seg0));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal digits of the value, then the segment pattern for the slot.
  function automatic logic [6:0] mdl_seg(input int v, input int pos, input bit lzb);
    int hun, ten, uni;
    hun = v / 100;
    ten = (v / 10) % 10;
    uni = v % 10;
    case (pos)
      0: return seg_tab[uni];
      1: return (lzb && hun == 0 && ten == 0) ? 7'b1111111 : seg_tab[ten];
      2: return (lzb && hun == 0) ? 7'b1111111 : seg_tab[hun];
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic load_val(input logic [7:0] v, output int bc);
    @(negedge clk);
    {dh, dl} = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bc = 0;
    while (busy1 && bc < 20) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic capture();
    for (int k = 0; k < 4; k++) begin
      cap1[k] = 7'h55;
      cap0[k] = 7'h55;
    end
    repeat (16) @(negedge clk);
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (an1 == an_seq[k]) cap1[k] = seg1;
        if (an0 == an_seq[k]) cap0[k] = seg0;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_display(input int v, input string tag);
    capture();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s v=%0d lzb1 slot%0d", tag, v, k), {25'd0, cap1[k]}, {25'd0, mdl_seg(v, k, 1'b1)});
      chk($sformatf("%s v=%0d lzb0 slot%0d", tag, v, k), {25'd0, cap0[k]}, {25'd0, mdl_seg(v, k, 1'b0)});
    end
  endtask

  initial begin
    int bc;
    int rv;

    vt[0] = '{8'hFF, 7'b0010010, 7'b0010010, 7'b0100100};
    vt[1] = '{8'h00, 7'b1000000, 7'b1111111, 7'b1111111};
    vt[2] = '{8'h07, 7'b1111000, 7'b1111111, 7'b1111111};
    vt[3] = '{8'h64, 7'b1000000, 7'b1000000, 7'b1111001};
    vt[4] = '{8'h0A, 7'b1000000, 7'b1111001, 7'b1111111};
    vt[5] = '{8'hC8, 7'b1000000, 7'b1000000, 7'b0100100};

    // Reset state and scan rotation timing
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy1}, 32'd0);
    chk("reset an", {28'd0, an1}, {28'd0, 4'b1111});
    chk("reset seg", {25'd0, seg1}, {25'd0, 7'b1111111});
    rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk($sformatf("scan an cyc%0d", i), {28'd0, an1},
          {28'd0, (i < 4) ? 4'b1111 : an_seq[(i / 4) % 4]});
    end

    // Directed vector table
    for (int i = 0; i < 6; i++) begin
      load_val(vt[i].val, bc);
      chk($sformatf("vec%0d busy cycles", i), bc, 8);
      capture();
      chk($sformatf("vec%0d slot0", i), {25'd0, cap1[0]}, {25'd0, vt[i].e0});
      chk($sformatf("vec%0d slot1", i), {25'd0, cap1[1]}, {25'd0, vt[i].e1});
      chk($sformatf("vec%0d slot2", i), {25'd0, cap1[2]}, {25'd0, vt[i].e2});
      chk($sformatf("vec%0d slot3", i), {25'd0, cap1[3]}, {25'd0, 7'b1111111});
    end

    // Loads during conversion, and on the final conversion edge, are dropped
    @(negedge clk);
    {dh, dl} = 8'h07;
    load = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      load = (k == 2 || k == 8) ? 1'b1 : 1'b0;
      {dh, dl} = (k >= 2) ? 8'h09 : 8'h07;
      chk($sformatf("drop busy n%0d", k), {31'd0, busy1}, 32'd1);
    end
    @(negedge clk);
    load = 1'b0;
    chk("drop final-edge load", {31'd0, busy1}, 32'd0);
    check_display(7, "drop");

    // Reset in the middle of a conversion
    @(negedge clk);
    {dh, dl} = 8'h64;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst busy before", {31'd0, busy1}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst busy", {31'd0, busy1}, 32'd0);
    chk("midrst an", {28'd0, an1}, {28'd0, 4'b1111});
    chk("midrst seg", {25'd0, seg1}, {25'd0, 7'b1111111});
    chk("midrst an lzb0", {28'd0, an0}, {28'd0, 4'b1111});
    @(negedge clk);
    rst = 1'b0;
    check_display(0, "midrst");
    chk("midrst stays idle", {31'd0, busy1}, 32'd0);

    // Randomized values
    for (int i = 0; i < 24; i++) begin
      rv = $urandom_range(0, 255);
      load_val(rv[7:0], bc);
      chk($sformatf("rand v=%0d busy cycles", rv), bc, 8);
      check_display(rv, "rand");
    end

    // Exhaustive sweep
    for (int v = 0; v < 256; v++) begin
      load_val(v[7:0], bc);
      chk($sformatf("sweep v=%0d busy cycles", v), bc, 8);
      check_display(v, "sweep");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
